// File: rtl/heat_timer.sv
// heat_timer: M:SS toaster countdown (start/pause/resume/abort) driving NCH duty-cycle PWM heaters.
// Optional soft-start ramp of heater duty over the first 10 s is enabled by HEAT_TIMER_SOFTSTART_EN.
module heat_timer #(
   parameter int NCH       = 2,
   parameter int TIME_W    = 10,
   parameter int TICK_DIV  = 50_000_000,
   parameter int PWM_PRESC = 500
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic [TIME_W-1:0] time_in,
   input  logic [8*NCH-1:0]  duty_in,
   input  logic              start,
   input  logic              pause,
   input  logic              stop,
   output logic              write_ack,
   output logic [NCH-1:0]    pwm,
   output logic [11:0]       tLED,
   output logic              busy,
   output logic              done
);
   localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int PRESC_W = (PWM_PRESC > 1) ? $clog2(PWM_PRESC) : 1;
   localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PWM_PRESC - 1);
   localparam logic [9:0]         SECS_MAX   = 10'd599;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [9:0]             secs_q, secs_d;
   logic [TICK_W-1:0]      tick_q, tick_d;
   logic [PRESC_W-1:0]     presc_q, presc_d;
   logic [6:0]             step_q, step_d;
   logic [NCH-1:0][6:0]    duty_q, duty_d;
   logic                   write_ack_q, write_ack_d;
   logic                   done_q, done_d;
   logic                   busy_q, busy_d;
   logic [NCH-1:0]         pwm_q, pwm_d;
   logic                   advance_s;
   logic [3:0]             mins_s, tens_s, ones_s;
   logic [9:0]             rem_s;
`ifdef HEAT_TIMER_SOFTSTART_EN
   logic [3:0]             elapsed_q, elapsed_d;
   logic [6:0]             ramp_s;
`endif

   function automatic logic [6:0] clamp_duty(input logic [7:0] d);
      if (d > 8'd100) begin
         return 7'd100;
      end else begin
         return d[6:0];
      end
   endfunction

   // Command decode (stop > load > start > pause) and run-time counter advance.
   always_comb begin
      state_d     = state_q;
      secs_d      = secs_q;
      tick_d      = tick_q;
      presc_d     = presc_q;
      step_d      = step_q;
      duty_d      = duty_q;
      write_ack_d = 1'b0;
      done_d      = 1'b0;
      advance_s   = 1'b0;
`ifdef HEAT_TIMER_SOFTSTART_EN
      elapsed_d   = elapsed_q;
`endif
      if (stop) begin
         state_d = IDLE;
         secs_d  = 10'd0;
         tick_d  = '0;
         presc_d = '0;
         step_d  = 7'd0;
`ifdef HEAT_TIMER_SOFTSTART_EN
         elapsed_d = 4'd0;
`endif
      end else if (load && (state_q == IDLE || state_q == DONE)) begin
         state_d     = IDLE;
         write_ack_d = 1'b1;
         tick_d      = '0;
         presc_d     = '0;
         step_d      = 7'd0;
`ifdef HEAT_TIMER_SOFTSTART_EN
         elapsed_d   = 4'd0;
`endif
         if (32'(time_in) > 32'd599) begin
            secs_d = SECS_MAX;
         end else begin
            secs_d = 10'(time_in);
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (start && secs_q != 10'd0) begin
                  state_d = RUN;
                  tick_d  = '0;
                  presc_d = '0;
                  step_d  = 7'd0;
`ifdef HEAT_TIMER_SOFTSTART_EN
                  elapsed_d = 4'd0;
`endif
                  for (int i = 0; i < NCH; i++) begin
                     duty_d[i] = clamp_duty(duty_in[8*i +: 8]);
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            RUN: begin
               // A simultaneous start masks pause so the countdown keeps running.
               if (pause && !start && !load) begin
                  state_d = PAUSE;
               end else begin
                  advance_s = 1'b1;
               end
            end
            PAUSE: begin
               if (start && !load) begin
                  state_d = RUN;
                  for (int i = 0; i < NCH; i++) begin
                     duty_d[i] = clamp_duty(duty_in[8*i +: 8]);
                  end
               end else begin
                  state_d = PAUSE;
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      if (advance_s) begin
         if (tick_q == TICK_LAST) begin
            tick_d = '0;
            secs_d = secs_q - 10'd1;
`ifdef HEAT_TIMER_SOFTSTART_EN
            if (elapsed_q < 4'd10) begin
               elapsed_d = elapsed_q + 4'd1;
            end else begin
               elapsed_d = elapsed_q;
            end
`endif
            if (secs_q == 10'd1) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               state_d = RUN;
            end
         end else begin
            tick_d = tick_q + TICK_W'(1);
         end
         if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (step_q == 7'd99) begin
               step_d = 7'd0;
            end else begin
               step_d = step_q + 7'd1;
            end
         end else begin
            presc_d = presc_q + PRESC_W'(1);
         end
      end else begin
         tick_d = tick_d;
      end
   end

   // Heater drive and busy flag, computed from the next-cycle state so they register alongside it.
   always_comb begin
      busy_d = (state_d == RUN) || (state_d == PAUSE);
      pwm_d  = '0;
`ifdef HEAT_TIMER_SOFTSTART_EN
      ramp_s = 7'(elapsed_d) * 7'd10;
`endif
      for (int i = 0; i < NCH; i++) begin
`ifdef HEAT_TIMER_SOFTSTART_EN
         if (duty_d[i] < ramp_s) begin
            pwm_d[i] = (state_d == RUN) && (step_d < duty_d[i]);
         end else begin
            pwm_d[i] = (state_d == RUN) && (step_d < ramp_s);
         end
`else
         pwm_d[i] = (state_d == RUN) && (step_d < duty_d[i]);
`endif
      end
   end

   // BCD display split of the seconds register.
   always_comb begin
      mins_s = 4'(secs_q / 10'd60);
      rem_s  = secs_q - (10'(mins_s) * 10'd60);
      tens_s = 4'(rem_s / 10'd10);
      ones_s = 4'(rem_s - (10'(tens_s) * 10'd10));
      tLED   = {mins_s, tens_s, ones_s};
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         secs_q      <= 10'd0;
         tick_q      <= '0;
         presc_q     <= '0;
         step_q      <= 7'd0;
         duty_q      <= '0;
         write_ack_q <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         pwm_q       <= '0;
`ifdef HEAT_TIMER_SOFTSTART_EN
         elapsed_q   <= 4'd0;
`endif
      end else begin
         state_q     <= state_d;
         secs_q      <= secs_d;
         tick_q      <= tick_d;
         presc_q     <= presc_d;
         step_q      <= step_d;
         duty_q      <= duty_d;
         write_ack_q <= write_ack_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         pwm_q       <= pwm_d;
`ifdef HEAT_TIMER_SOFTSTART_EN
         elapsed_q   <= elapsed_d;
`endif
      end
   end

   assign write_ack = write_ack_q;
   assign done      = done_q;
   assign busy      = busy_q;
   assign pwm       = pwm_q;
endmodule

// File: tb/tb_heat_timer.sv
// Bench for heat_timer: directed spec scenarios plus random commands against a run-time arithmetic model.
module tb_heat_timer;
   localparam int NCH       = 2;
   localparam int TIME_W    = 10;
   localparam int TICK_DIV  = 10;
   localparam int PWM_PRESC = 1;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              load = 1'b0;
   logic              start = 1'b0;
   logic              pause = 1'b0;
   logic              stop = 1'b0;
   logic [TIME_W-1:0] time_in = '0;
   logic [8*NCH-1:0]  duty_in = '0;
   logic              write_ack;
   logic [NCH-1:0]    pwm;
   logic [11:0]       tLED;
   logic              busy;
   logic              done;

   heat_timer #(.NCH(NCH), .TIME_W(TIME_W), .TICK_DIV(TICK_DIV), .PWM_PRESC(PWM_PRESC)) dut (
      .clk(clk), .reset_n(reset_n), .load(load), .time_in(time_in), .duty_in(duty_in),
      .start(start), .pause(pause), .stop(stop), .write_ack(write_ack), .pwm(pwm),
      .tLED(tLED), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model: mode 0 idle, 1 run, 2 pause, 3 done; secs = base - run_cycles/TICK_DIV.
   int m_st = 0;
   int m_base = 0;
   int m_rc = 0;
   int m_duty[NCH];
   bit m_ack = 1'b0;
   bit m_done = 1'b0;

   function automatic int m_secs();
      return m_base - (m_rc / TICK_DIV);
   endfunction

   function automatic logic [NCH-1:0] exp_pwm();
      logic [NCH-1:0] r;
      int eff;
      r = '0;
      for (int i = 0; i < NCH; i++) begin
         eff = m_duty[i];
`ifdef HEAT_TIMER_SOFTSTART_EN
         if (10 * ((m_rc / TICK_DIV) > 10 ? 10 : (m_rc / TICK_DIV)) < eff)
            eff = 10 * ((m_rc / TICK_DIV) > 10 ? 10 : (m_rc / TICK_DIV));
`endif
         r[i] = (m_st == 1) && (((m_rc / PWM_PRESC) % 100) < eff);
      end
      return r;
   endfunction

   function automatic logic [11:0] exp_tled();
      int s;
      s = m_secs();
      return {4'(s / 60), 4'((s % 60) / 10), 4'(s % 10)};
   endfunction

   task automatic latch_duty();
      for (int i = 0; i < NCH; i++) begin
         m_duty[i] = (duty_in[8*i +: 8] > 8'd100) ? 100 : int'(duty_in[8*i +: 8]);
      end
   endtask

   task automatic model_update();
      m_ack  = 1'b0;
      m_done = 1'b0;
      if (!reset_n) begin
         m_st = 0; m_base = 0; m_rc = 0;
         for (int i = 0; i < NCH; i++) m_duty[i] = 0;
      end else if (stop) begin
         m_st = 0; m_base = 0; m_rc = 0;
      end else if (load && (m_st == 0 || m_st == 3)) begin
         m_st = 0; m_rc = 0; m_ack = 1'b1;
         m_base = (int'(time_in) > 599) ? 599 : int'(time_in);
      end else if (m_st == 0 && start && m_secs() > 0) begin
         m_st = 1; m_rc = 0; latch_duty();
      end else if (m_st == 2 && start && !load) begin
         m_st = 1; latch_duty();
      end else if (m_st == 1 && pause && !start && !load) begin
         m_st = 2;
      end else if (m_st == 1) begin
         m_rc++;
         if (m_secs() == 0) begin
            m_st = 3; m_done = 1'b1;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         model_update();
         #1;
         check("write_ack", 32'(write_ack), 32'(m_ack));
         check("done", 32'(done), 32'(m_done));
         check("busy", 32'(busy), 32'(m_st == 1 || m_st == 2));
         check("pwm", 32'(pwm), 32'(exp_pwm()));
         check("tLED", 32'(tLED), 32'(exp_tled()));
      end
   endtask

   task automatic do_load(input int t);
      time_in = TIME_W'(t); load = 1'b1; cyc(1); load = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1; cyc(1); start = 1'b0;
   endtask

   int hi0, hi1, n;

   initial begin
      for (int i = 0; i < NCH; i++) m_duty[i] = 0;
      reset_n = 1'b0;
      cyc(3);
      check("rst_tled", 32'(tLED), 32'h000);
      check("rst_outs", 32'({write_ack, pwm, busy, done}), 32'h0);
      reset_n = 1'b1;
      duty_in = {8'd0, 8'd50};

      do_load(75);
      check("ack_75", 32'(write_ack), 32'h1);
      check("tled_75", 32'(tLED), 32'h115);
      cyc(1);
      check("ack_single", 32'(write_ack), 32'h0);
      do_load(700);
      check("tled_clamp", 32'(tLED), 32'h959);

      do_load(20);
      do_start();
      hi0 = 0; hi1 = 0;
      for (int k = 0; k < 100; k++) begin
         cyc(1);
         hi0 += int'(pwm[0]);
         hi1 += int'(pwm[1]);
      end
`ifndef HEAT_TIMER_SOFTSTART_EN
      check("pwm0_half", 32'(hi0), 32'd50);
`endif
      check("pwm1_off", 32'(hi1), 32'd0);
      do_load(9);
      check("ack_in_run", 32'(write_ack), 32'h0);
      check("tled_in_run", 32'(tLED), 32'h010);
      stop = 1'b1; cyc(1); stop = 1'b0;
      check("stop_tled", 32'(tLED), 32'h000);
      check("stop_busy", 32'({busy, done, pwm}), 32'h0);

      do_load(3);
      do_start();
      n = 0;
      while (!done && n < 100) begin
         cyc(1);
         n++;
         if (n == 10) check("sec_at_10", 32'(tLED), 32'h002);
         if (n == 20) check("sec_at_20", 32'(tLED), 32'h001);
      end
      check("done_at_30", 32'(n), 32'd30);
      check("done_state", 32'({busy, pwm}), 32'h0);
      cyc(1);
      check("done_single", 32'(done), 32'h0);
      do_start();
      check("start_in_done", 32'(busy), 32'h0);

      do_load(5);
      do_start();
      cyc(25);
      pause = 1'b1; cyc(1); pause = 1'b0;
      check("pause_tled", 32'(tLED), 32'h003);
      check("pause_pwm", 32'(pwm), 32'h0);
      cyc(7);
      check("pause_hold", 32'(tLED), 32'h003);
      do_start();
      cyc(4);
      check("resume_4", 32'(tLED), 32'h003);
      cyc(1);
      check("resume_5", 32'(tLED), 32'h002);
      start = 1'b1; pause = 1'b1; cyc(1); start = 1'b0; pause = 1'b0;
      check("start_pause_busy", 32'(busy), 32'h1);
      cyc(10);
      check("start_pause_runs", 32'(tLED), 32'h001);

      stop = 1'b1; cyc(1); stop = 1'b0;
      do_start();
      check("start_zero", 32'(busy), 32'h0);

      duty_in = {8'd0, 8'd150};
      do_load(30);
      do_start();
      hi0 = 0;
      for (int k = 0; k < 100; k++) begin
         cyc(1);
         hi0 += int'(pwm[0]);
      end
`ifndef HEAT_TIMER_SOFTSTART_EN
      check("duty_150", 32'(hi0), 32'd100);
`endif
      reset_n = 1'b0; cyc(1);
      check("rst_run", 32'({write_ack, pwm, busy, done, tLED}), 32'h0);
      reset_n = 1'b1;

      for (int k = 0; k < 4000; k++) begin
         reset_n = ($urandom_range(0, 599) != 0);
         stop    = ($urandom_range(0, 59) == 0);
         load    = ($urandom_range(0, 29) == 0);
         start   = ($urandom_range(0, 9) == 0);
         pause   = ($urandom_range(0, 19) == 0);
         time_in = ($urandom_range(0, 3) == 0) ? TIME_W'($urandom_range(0, 1023))
                                              : TIME_W'($urandom_range(0, 12));
         duty_in = {8'($urandom_range(0, 160)), 8'($urandom_range(0, 160))};
         cyc(1);
      end
      reset_n = 1'b1; stop = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
      cyc(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
